// File: rtl/jedro_1_csr_file.sv
// Machine-mode CSR file for the jedro_1 core.
// Executes the six Zicsr ops and returns the old CSR value one cycle later.
// Also handles trap entry, mret, and the free-running mcycle/minstret counters.
// Ports:
//   clk_i, rstn_i        clock and synchronous active-low reset
//   csr_*_i              CSR request from the decoder (op, address, operands)
//   csr_rdata_o          old CSR value (0 on a faulting access)
//   csr_rvalid_o         one-cycle pulse marking csr_rdata_o/csr_illegal_o valid
//   csr_illegal_o        the access faulted
//   instr_ret_i          one instruction retired this cycle
//   trap_i, trap_*_i     trap entry, with the cause and pc to record
//   mret_i               mret executed
//   mtvec_o, mepc_o      current mtvec and mepc
//   mie_o                current mstatus.MIE
module jedro_1_csr_file #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           CNT_WIDTH   = 64,
    parameter logic [DATA_WIDTH-1:0] MTVEC_RESET = '0,
    parameter int unsigned           MHARTID     = 0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  csr_en_i,
    input  logic [2:0]            csr_op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [DATA_WIDTH-1:0] csr_wdata_i,
    input  logic [4:0]            csr_uimm_i,
    input  logic                  csr_rs1_zero_i,
    output logic [DATA_WIDTH-1:0] csr_rdata_o,
    output logic                  csr_rvalid_o,
    output logic                  csr_illegal_o,
    input  logic                  instr_ret_i,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_cause_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic                  mret_i,
    output logic [DATA_WIDTH-1:0] mtvec_o,
    output logic [DATA_WIDTH-1:0] mepc_o,
    output logic                  mie_o
);

    localparam int unsigned CNT2_W = 2 * DATA_WIDTH;
    localparam bit          HAS_HI = (CNT_WIDTH == 64);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [DATA_WIDTH-1:0] MISA_VAL   = DATA_WIDTH'(32'h4000_0100);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    logic                  mpie_q;
    logic [DATA_WIDTH-1:0] mscratch_q;
    logic [DATA_WIDTH-1:0] mcause_q;
    logic [DATA_WIDTH-1:0] cyc_lo_q, cyc_hi_q, ins_lo_q, ins_hi_q;

    logic [DATA_WIDTH-1:0] operand_c, old_c, new_c;
    logic                  impl_c, ro_c, wr_intent_c, op_ok_c, illegal_c;
    logic                  access_c, do_write_c;
    logic [CNT2_W-1:0]     cyc_nxt_c, ins_nxt_c;

    // Next counter value: a write to one half wins and freezes the other half.
    function automatic logic [CNT2_W-1:0] cnt_next(
        input logic [DATA_WIDTH-1:0] hi,
        input logic [DATA_WIDTH-1:0] lo,
        input logic                  inc,
        input logic                  wr_lo,
        input logic                  wr_hi,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [CNT2_W-1:0] nxt;
        if (wr_lo)       nxt = {hi, wdata};
        else if (wr_hi)  nxt = {wdata, lo};
        else if (inc)    nxt = {hi, lo} + CNT2_W'(1);
        else             nxt = {hi, lo};
        if (!HAS_HI) nxt[CNT2_W-1:DATA_WIDTH] = '0;
        return nxt;
    endfunction

    // Request decode: operand, write intent, old value, fault detection.
    always_comb begin
        operand_c = csr_op_i[2] ? DATA_WIDTH'(csr_uimm_i) : csr_wdata_i;
        op_ok_c   = (csr_op_i[1:0] != 2'b00);

        if (csr_op_i[1:0] == 2'b01) wr_intent_c = 1'b1;
        else if (csr_op_i[2])       wr_intent_c = (csr_uimm_i != 5'd0);
        else                        wr_intent_c = !csr_rs1_zero_i;

        case (csr_op_i[1:0])
            2'b01:   new_c = operand_c;
            2'b10:   new_c = old_c | operand_c;
            default: new_c = old_c & ~operand_c;
        endcase

        old_c  = '0;
        impl_c = 1'b1;
        case (csr_addr_i)
            ADDR_MSTATUS:   old_c = DATA_WIDTH'({mpie_q, 3'b000, mie_o, 3'b000});
            ADDR_MISA:      old_c = MISA_VAL;
            ADDR_MTVEC:     old_c = mtvec_o;
            ADDR_MSCRATCH:  old_c = mscratch_q;
            ADDR_MEPC:      old_c = mepc_o;
            ADDR_MCAUSE:    old_c = mcause_q;
            ADDR_MCYCLE:    old_c = cyc_lo_q;
            ADDR_MCYCLEH:   old_c = cyc_hi_q;
            ADDR_MINSTRET:  old_c = ins_lo_q;
            ADDR_MINSTRETH: old_c = ins_hi_q;
            ADDR_MHARTID:   old_c = DATA_WIDTH'(MHARTID);
            default:        impl_c = 1'b0;
        endcase

        ro_c       = (csr_addr_i[11:10] == 2'b11) || (csr_addr_i == ADDR_MISA);
        illegal_c  = !impl_c || !op_ok_c || (wr_intent_c && ro_c);
        // trap and mret both pre-empt a CSR access in the same cycle
        access_c   = csr_en_i && !trap_i && !mret_i;
        do_write_c = access_c && !illegal_c && wr_intent_c;

        cyc_nxt_c = cnt_next(cyc_hi_q, cyc_lo_q, 1'b1,
                             do_write_c && (csr_addr_i == ADDR_MCYCLE),
                             do_write_c && (csr_addr_i == ADDR_MCYCLEH) && HAS_HI,
                             new_c);
        ins_nxt_c = cnt_next(ins_hi_q, ins_lo_q, instr_ret_i,
                             do_write_c && (csr_addr_i == ADDR_MINSTRET),
                             do_write_c && (csr_addr_i == ADDR_MINSTRETH) && HAS_HI,
                             new_c);
    end

    // State update: read-back, trap/mret, CSR writes, counters.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            csr_rdata_o   <= '0;
            csr_rvalid_o  <= 1'b0;
            csr_illegal_o <= 1'b0;
            mie_o         <= 1'b0;
            mpie_q        <= 1'b0;
            mtvec_o       <= MTVEC_RESET;
            mepc_o        <= '0;
            mscratch_q    <= '0;
            mcause_q      <= '0;
            cyc_lo_q      <= '0;
            cyc_hi_q      <= '0;
            ins_lo_q      <= '0;
            ins_hi_q      <= '0;
        end else begin
            csr_rvalid_o  <= access_c;
            csr_illegal_o <= access_c && illegal_c;
            csr_rdata_o   <= (access_c && !illegal_c) ? old_c : '0;

            if (trap_i) begin
                mepc_o   <= trap_pc_i & ALIGN_MASK;
                mcause_q <= trap_cause_i;
                mpie_q   <= mie_o;
                mie_o    <= 1'b0;
            end else if (mret_i) begin
                mie_o  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (do_write_c) begin
                case (csr_addr_i)
                    ADDR_MSTATUS: begin
                        mie_o  <= new_c[3];
                        mpie_q <= new_c[7];
                    end
                    ADDR_MTVEC:    mtvec_o    <= new_c & ALIGN_MASK;
                    ADDR_MSCRATCH: mscratch_q <= new_c;
                    ADDR_MEPC:     mepc_o     <= new_c & ALIGN_MASK;
                    ADDR_MCAUSE:   mcause_q   <= new_c;
                    default: ;
                endcase
            end

            {cyc_hi_q, cyc_lo_q} <= cyc_nxt_c;
            {ins_hi_q, ins_lo_q} <= ins_nxt_c;
        end
    end

endmodule

// File: tb/tb_jedro_1_csr_file.sv
module tb_jedro_1_csr_file;

    localparam logic [31:0] MTVEC_RST = 32'h8000_0100;
    localparam int unsigned HART      = 7;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        csr_en_i;
    logic [2:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [4:0]  csr_uimm_i;
    logic        csr_rs1_zero_i;
    logic [31:0] csr_rdata_o;
    logic        csr_rvalid_o;
    logic        csr_illegal_o;
    logic        instr_ret_i;
    logic        trap_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic        mret_i;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_o;

    jedro_1_csr_file #(
        .DATA_WIDTH  (32),
        .CNT_WIDTH   (64),
        .MTVEC_RESET (MTVEC_RST),
        .MHARTID     (HART)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn_i),
        .csr_en_i       (csr_en_i),
        .csr_op_i       (csr_op_i),
        .csr_addr_i     (csr_addr_i),
        .csr_wdata_i    (csr_wdata_i),
        .csr_uimm_i     (csr_uimm_i),
        .csr_rs1_zero_i (csr_rs1_zero_i),
        .csr_rdata_o    (csr_rdata_o),
        .csr_rvalid_o   (csr_rvalid_o),
        .csr_illegal_o  (csr_illegal_o),
        .instr_ret_i    (instr_ret_i),
        .trap_i         (trap_i),
        .trap_cause_i   (trap_cause_i),
        .trap_pc_i      (trap_pc_i),
        .mret_i         (mret_i),
        .mtvec_o        (mtvec_o),
        .mepc_o         (mepc_o),
        .mie_o          (mie_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;
    logic        exp_rvalid, exp_ill;
    logic [31:0] exp_rdata;

    function automatic logic model_read(input logic [11:0] a, output logic [31:0] v);
        logic known = 1'b1;
        v = 32'h0;
        case (a)
            12'h300: v = m_mstatus;
            12'h301: v = 32'h4000_0100;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[31:0];
            12'hB82: v = m_ins[63:32];
            12'hF14: v = HART;
            default: known = 1'b0;
        endcase
        return known;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic        accept, known, ro, wants;
        logic        cyc_w, ins_w;
        logic [31:0] old, opnd, nv;
        cyc_w = 1'b0;
        ins_w = 1'b0;
        if (!rstn_i) begin
            m_mstatus = 0; m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
            m_cyc = 0; m_ins = 0;
            exp_rvalid = 0; exp_ill = 0; exp_rdata = 0;
            return;
        end
        accept     = csr_en_i && !trap_i && !mret_i;
        exp_rvalid = accept;
        exp_ill    = 1'b0;
        exp_rdata  = 32'h0;
        if (accept) begin
            known = model_read(csr_addr_i, old);
            ro    = (csr_addr_i[11:10] == 2'b11) || (csr_addr_i == 12'h301);
            opnd  = csr_op_i[2] ? {27'h0, csr_uimm_i} : csr_wdata_i;
            wants = (csr_op_i == 3'd1) || (csr_op_i == 3'd5)
                 || (((csr_op_i == 3'd2) || (csr_op_i == 3'd3)) && !csr_rs1_zero_i)
                 || (((csr_op_i == 3'd6) || (csr_op_i == 3'd7)) && (csr_uimm_i != 0));
            if (!known || csr_op_i == 3'd0 || csr_op_i == 3'd4 || (wants && ro)) begin
                exp_ill = 1'b1;
            end else begin
                exp_rdata = old;
                if (wants) begin
                    if (csr_op_i == 3'd1 || csr_op_i == 3'd5)      nv = opnd;
                    else if (csr_op_i == 3'd2 || csr_op_i == 3'd6) nv = old | opnd;
                    else                                           nv = old & ~opnd;
                    case (csr_addr_i)
                        12'h300: m_mstatus  = nv & 32'h88;
                        12'h305: m_mtvec    = nv & ~32'h3;
                        12'h340: m_mscratch = nv;
                        12'h341: m_mepc     = nv & ~32'h3;
                        12'h342: m_mcause   = nv;
                        12'hB00: begin m_cyc = {m_cyc[63:32], nv}; cyc_w = 1; end
                        12'hB80: begin m_cyc = {nv, m_cyc[31:0]};  cyc_w = 1; end
                        12'hB02: begin m_ins = {m_ins[63:32], nv}; ins_w = 1; end
                        12'hB82: begin m_ins = {nv, m_ins[31:0]};  ins_w = 1; end
                        default: ;
                    endcase
                end
            end
        end
        if (trap_i) begin
            m_mepc    = trap_pc_i & ~32'h3;
            m_mcause  = trap_cause_i;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        end else if (mret_i) begin
            m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end
        if (!cyc_w) m_cyc = m_cyc + 1;
        if (!ins_w && instr_ret_i) m_ins = m_ins + 1;
    endtask

    // One clock: advance the model, then compare DUT outputs 1 time unit after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("rvalid", csr_rvalid_o, exp_rvalid);
        if (exp_rvalid) begin
            check("illegal", csr_illegal_o, exp_ill);
            check("rdata", csr_rdata_o, exp_rdata);
        end
        check("mtvec_o", mtvec_o, m_mtvec);
        check("mepc_o", mepc_o, m_mepc);
        check("mie_o", mie_o, m_mstatus[3]);
    endtask

    task automatic set_idle();
        csr_en_i = 0; csr_op_i = 3'd0; csr_addr_i = 12'h0; csr_wdata_i = 0;
        csr_uimm_i = 0; csr_rs1_zero_i = 1; instr_ret_i = 0; trap_i = 0;
        trap_cause_i = 0; trap_pc_i = 0; mret_i = 0;
    endtask

    // Issue one access and compare against hand-derived expectations.
    task automatic do_csr(input string name, input logic [2:0] op, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [4:0] uimm, input logic rs1z,
                          input logic e_ill, input logic [31:0] e_rdata);
        csr_en_i = 1; csr_op_i = op; csr_addr_i = addr; csr_wdata_i = wdata;
        csr_uimm_i = uimm; csr_rs1_zero_i = rs1z;
        tick();
        csr_en_i = 0;
        check({name, ".rvalid"}, csr_rvalid_o, 1'b1);
        check({name, ".illegal"}, csr_illegal_o, e_ill);
        check({name, ".rdata"}, csr_rdata_o, e_rdata);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [4:0]  uimm;
        logic        rs1z;
        logic        e_ill;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] RW = 3'd1, RS = 3'd2, RC = 3'd3, RWI = 3'd5, RSI = 3'd6, RCI = 3'd7;

    initial begin
        set_idle();
        rstn_i = 0;

        vecs.push_back('{"scr_pre",    RW,  12'h340, 32'h3,        5'd0, 0, 0, 32'h0});
        vecs.push_back('{"scr_rw",     RW,  12'h340, 32'h55F,      5'd0, 0, 0, 32'h3});
        vecs.push_back('{"scr_rd",     RS,  12'h340, 32'h0,        5'd0, 1, 0, 32'h55F});
        vecs.push_back('{"cause_rw",   RW,  12'h342, 32'h3,        5'd0, 0, 0, 32'h0});
        vecs.push_back('{"cause_rd",   RS,  12'h342, 32'h0,        5'd0, 1, 0, 32'h3});
        vecs.push_back('{"scr_f0",     RW,  12'h340, 32'hF0,       5'd0, 0, 0, 32'h55F});
        vecs.push_back('{"scr_rs",     RS,  12'h340, 32'h0F,       5'd0, 0, 0, 32'hF0});
        vecs.push_back('{"scr_rci",    RCI, 12'h340, 32'h0,        5'd3, 0, 0, 32'hFF});
        vecs.push_back('{"scr_rs_x0",  RS,  12'h340, 32'h0,        5'd0, 1, 0, 32'hFC});
        vecs.push_back('{"scr_rc_x0",  RC,  12'h340, 32'h0,        5'd0, 1, 0, 32'hFC});
        vecs.push_back('{"scr_rsi0",   RSI, 12'h340, 32'h0,        5'd0, 0, 0, 32'hFC});
        vecs.push_back('{"hart_rw",    RW,  12'hF14, 32'h1,        5'd0, 0, 1, 32'h0});
        vecs.push_back('{"hart_rd",    RS,  12'hF14, 32'h0,        5'd0, 1, 0, HART});
        vecs.push_back('{"hart_rci0",  RCI, 12'hF14, 32'h0,        5'd0, 0, 0, HART});
        vecs.push_back('{"unimpl",     RS,  12'h7C0, 32'h0,        5'd0, 1, 1, 32'h0});
        vecs.push_back('{"misa_rd",    RS,  12'h301, 32'h0,        5'd0, 1, 0, 32'h4000_0100});
        vecs.push_back('{"misa_wr",    RSI, 12'h301, 32'h0,        5'd1, 0, 1, 32'h0});
        vecs.push_back('{"op000",      3'd0, 12'h340, 32'h1,       5'd0, 0, 1, 32'h0});
        vecs.push_back('{"op100",      3'd4, 12'h340, 32'h1,       5'd1, 0, 1, 32'h0});
        vecs.push_back('{"scr_after",  RS,  12'h340, 32'h0,        5'd0, 1, 0, 32'hFC});
        vecs.push_back('{"mtvec_rwi",  RWI, 12'h305, 32'h0,        5'h1F, 0, 0, MTVEC_RST});
        vecs.push_back('{"mtvec_rd",   RS,  12'h305, 32'h0,        5'd0, 1, 0, 32'h1C});
        vecs.push_back('{"mepc_rw",    RW,  12'h341, 32'hFFFF_FFFF, 5'd0, 0, 0, 32'h0});
        vecs.push_back('{"mepc_rd",    RS,  12'h341, 32'h0,        5'd0, 1, 0, 32'hFFFF_FFFC});
        vecs.push_back('{"mst_rw",     RW,  12'h300, 32'hFFFF_FFFF, 5'd0, 0, 0, 32'h0});
        vecs.push_back('{"mst_clr",    RW,  12'h300, 32'h0,        5'd0, 0, 0, 32'h88});

        // reset state
        tick();
        tick();
        check("rst.rvalid", csr_rvalid_o, 1'b0);
        check("rst.illegal", csr_illegal_o, 1'b0);
        check("rst.rdata", csr_rdata_o, 32'h0);
        check("rst.mtvec", mtvec_o, MTVEC_RST);
        check("rst.mepc", mepc_o, 32'h0);
        check("rst.mie", mie_o, 1'b0);
        rstn_i = 1;

        foreach (vecs[i])
            do_csr(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].uimm,
                   vecs[i].rs1z, vecs[i].e_ill, vecs[i].e_rdata);

        // trap entry then mret
        do_csr("mie_set", RSI, 12'h300, 32'h0, 5'd8, 0, 0, 32'h0);
        check("mie_set.mie", mie_o, 1'b1);
        trap_i = 1; trap_cause_i = 32'h8000_000B; trap_pc_i = 32'h107;
        tick();
        trap_i = 0;
        check("trap.mepc", mepc_o, 32'h104);
        check("trap.mie", mie_o, 1'b0);
        do_csr("trap.mcause", RS, 12'h342, 32'h0, 5'd0, 1, 0, 32'h8000_000B);
        do_csr("trap.mstatus", RS, 12'h300, 32'h0, 5'd0, 1, 0, 32'h80);
        mret_i = 1;
        tick();
        mret_i = 0;
        check("mret.mie", mie_o, 1'b1);
        do_csr("mret.mstatus", RS, 12'h300, 32'h0, 5'd0, 1, 0, 32'h88);

        // counter wrap with write-wins-over-increment
        do_csr("cyc_lo_w", RW, 12'hB00, 32'hFFFF_FFFF, 5'd0, 0, 0, m_cyc[31:0]);
        do_csr("cyc_hi_w", RW, 12'hB80, 32'hFFFF_FFFF, 5'd0, 0, 0, m_cyc[63:32]);
        tick();
        do_csr("cyc_wrap_lo", RS, 12'hB00, 32'h0, 5'd0, 1, 0, 32'h0);
        do_csr("cyc_wrap_hi", RS, 12'hB80, 32'h0, 5'd0, 1, 0, 32'h0);

        // minstret counts retire pulses only
        do_csr("ins_clr_lo", RW, 12'hB02, 32'h0, 5'd0, 0, 0, m_ins[31:0]);
        do_csr("ins_clr_hi", RW, 12'hB82, 32'h0, 5'd0, 0, 0, m_ins[63:32]);
        for (int k = 0; k < 5; k++) begin
            instr_ret_i = 1; tick();
            instr_ret_i = 0; tick();
        end
        do_csr("ins_five", RS, 12'hB02, 32'h0, 5'd0, 1, 0, 32'd5);
        instr_ret_i = 1;
        do_csr("ins_w_win", RW, 12'hB02, 32'd10, 5'd0, 0, 0, 32'd5);
        instr_ret_i = 0;
        do_csr("ins_ten", RS, 12'hB02, 32'h0, 5'd0, 1, 0, 32'd10);

        // trap / mret suppress a same-cycle access
        trap_i = 1; trap_pc_i = 32'h200; trap_cause_i = 32'h2;
        csr_en_i = 1; csr_op_i = RW; csr_addr_i = 12'h340; csr_wdata_i = 32'hDEAD;
        tick();
        set_idle();
        check("trap_sup.rvalid", csr_rvalid_o, 1'b0);
        mret_i = 1;
        csr_en_i = 1; csr_op_i = RW; csr_addr_i = 12'h340; csr_wdata_i = 32'hBEEF;
        tick();
        set_idle();
        check("mret_sup.rvalid", csr_rvalid_o, 1'b0);
        do_csr("sup.scr", RS, 12'h340, 32'h0, 5'd0, 1, 0, 32'hFC);

        // reset during a pending access
        csr_en_i = 1; csr_op_i = RW; csr_addr_i = 12'h340; csr_wdata_i = 32'h1234;
        rstn_i = 0;
        tick();
        set_idle();
        check("rst_acc.rvalid", csr_rvalid_o, 1'b0);
        rstn_i = 1;
        tick();
        check("rst_acc.rvalid2", csr_rvalid_o, 1'b0);
        do_csr("rst.scr", RS, 12'h340, 32'h0, 5'd0, 1, 0, 32'h0);
        do_csr("rst.cause", RS, 12'h342, 32'h0, 5'd0, 1, 0, 32'h0);
        do_csr("rst.mstatus", RS, 12'h300, 32'h0, 5'd0, 1, 0, 32'h0);
        do_csr("rst.mtvec_rd", RS, 12'h305, 32'h0, 5'd0, 1, 0, MTVEC_RST);
        do_csr("rst.ins", RS, 12'hB02, 32'h0, 5'd0, 1, 0, 32'h0);

        // randomized traffic against the model
        begin
            logic [11:0] addrs[14] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                       12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14,
                                       12'h7C0, 12'h344, 12'hF11};
            for (int n = 0; n < 3000; n++) begin
                rstn_i         = ($urandom_range(0, 199) != 0);
                csr_en_i       = ($urandom_range(0, 9) < 7);
                csr_op_i       = 3'($urandom_range(0, 7));
                csr_addr_i     = addrs[$urandom_range(0, 13)];
                csr_wdata_i    = $urandom;
                csr_uimm_i     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                csr_rs1_zero_i = ($urandom_range(0, 3) == 0);
                instr_ret_i    = 1'($urandom);
                trap_i         = ($urandom_range(0, 19) == 0);
                mret_i         = ($urandom_range(0, 19) == 0);
                trap_cause_i   = $urandom;
                trap_pc_i      = $urandom;
                tick();
            end
        end

        set_idle();
        rstn_i = 1;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
